mnist_image_feeder: RTL

Dataset-side responder for the CNN top level. It watches the image index requested by the network, fetches the matching record (label byte plus row-major 8-bit pixels) from a byte-wide synchronous ROM/BRAM, and converts pixels to signed fixed point. It one-hot encodes the label. A double buffer keeps the image/label arrays presented to the network stable while the next record loads, and swaps them atomically when the load completes.

---
 rtl/mnist_image_feeder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mnist_image_feeder.sv
// rtl/mnist_image_feeder.sv - fetches an MNIST record from byte ROM into double-buffered fixed-point arrays
module mnist_image_feeder #(
    parameter int WIDTH             = 32,
    parameter int FIXED_POINT_INDEX = 16,
    parameter int IMG_HEIGHT        = 28,
    parameter int IMG_WIDTH         = 28,
    parameter int NUM_CLASSES       = 10,
    parameter int NUM_IMAGES        = 10000,
    parameter int LABEL_ONE         = 1,
    localparam int RECORD_BYTES     = IMG_HEIGHT*IMG_WIDTH+1,
    localparam int ADDR_W           = $clog2(NUM_IMAGES*RECORD_BYTES),
    localparam int IDX_W            = $clog2(NUM_IMAGES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IDX_W-1:0]        input_index,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [7:0]              mem_rdata,
    output logic signed [WIDTH-1:0] image_data [IMG_HEIGHT][IMG_WIDTH],
    output logic signed [WIDTH-1:0] labels [NUM_CLASSES],
    output logic                    ready,
    output logic                    label_error
);
    localparam int NPIX  = IMG_HEIGHT*IMG_WIDTH;
    localparam int PIX_W = $clog2(NPIX);
    localparam int CNT_W = $clog2(RECORD_BYTES+1);
    localparam int SHIFT = FIXED_POINT_INDEX-8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RECORD_BYTES-1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SWAP} state_t;

    state_t             state, state_next;
    logic               loaded_valid;
    logic [IDX_W-1:0]   loaded_index;
    logic [IDX_W-1:0]   target_index;
    logic [ADDR_W-1:0]  base;
    logic [CNT_W-1:0]   issue_cnt;
    logic               issue_done;
    logic [CNT_W-1:0]   cap_cnt;
    logic               cap_valid;
    logic               start_load;

    logic [7:0]         shadow_label;
    logic [7:0]         shadow_pix [NPIX];
    logic [7:0]         active_pix [NPIX];

    always_comb begin
        state_next = state;
        start_load = 1'b0;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        case (state)
            S_IDLE: begin
                if (!loaded_valid || input_index != loaded_index) begin
                    start_load = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_rd_en = !issue_done;
                if (!issue_done)
                    mem_addr = base + ADDR_W'(issue_cnt);
                // A new request restarts the load; the read issued this cycle is never captured.
                if (input_index != target_index)
                    start_load = 1'b1;
                else if (cap_valid && cap_cnt == LAST)
                    state_next = S_SWAP;
            end
            S_SWAP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            loaded_valid <= 1'b0;
            loaded_index <= '0;
            target_index <= '0;
            base         <= '0;
            issue_cnt    <= '0;
            issue_done   <= 1'b0;
            cap_cnt      <= '0;
            cap_valid    <= 1'b0;
            ready        <= 1'b0;
            label_error  <= 1'b0;
            active_pix   <= '{default: '0};
            labels       <= '{default: '0};
        end else begin
            state     <= state_next;
            cap_valid <= mem_rd_en && !start_load;
            cap_cnt   <= issue_cnt;
            if (start_load) begin
                target_index <= input_index;
                base         <= ADDR_W'(input_index) * ADDR_W'(RECORD_BYTES);
                issue_cnt    <= '0;
                issue_done   <= 1'b0;
                ready        <= 1'b0;
            end else if (mem_rd_en) begin
                if (issue_cnt == LAST)
                    issue_done <= 1'b1;
                else
                    issue_cnt <= issue_cnt + 1'b1;
            end
            if (state == S_SWAP) begin
                active_pix   <= shadow_pix;
                for (int k = 0; k < NUM_CLASSES; k++)
                    labels[k] <= (32'(shadow_label) == k) ? WIDTH'(LABEL_ONE) : '0;
                label_error  <= 32'(shadow_label) >= NUM_CLASSES;
                loaded_index <= target_index;
                loaded_valid <= 1'b1;
                ready        <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_valid && !start_load) begin
            if (cap_cnt == '0)
                shadow_label <= mem_rdata;
            else
                shadow_pix[PIX_W'(cap_cnt - CNT_W'(1))] <= mem_rdata;
        end
    end

    for (genvar r = 0; r < IMG_HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < IMG_WIDTH; c++) begin : g_col
            assign image_data[r][c] = $signed(WIDTH'(active_pix[r*IMG_WIDTH+c]) << SHIFT);
        end
    end
endmodule
